serial_to_parallel_rx: RTL and testbench

Receive-side deserializer and byte aligner for the phy_rx path. It sits directly upstream of the layer-2 demultiplexer and feeds it `data_000`/`valid_000`. It converts the incoming 1-bit serial line, clocked at `clk_16f`, into aligned bytes at the `clk_2f` byte rate, with one byte per 8 `clk_16f` cycles. It locks onto the 0xBC comma character before passing any payload downstream.

---
 rtl/serial_to_parallel_rx_if.sv | 22 ++
 rtl/serial_to_parallel_rx.sv | 115 +++++++++++
 tb/tb_serial_to_parallel_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_rx_if.sv
// Byte-side bundle between the phy_rx deserializer (master) and the layer-2 demux (slave).
// The serial line data_in travels with it so the whole datapath stays in one bundle.
interface serial_to_parallel_rx_if;
  logic       data_in;
  logic [7:0] data_000;
  logic       valid_000;
  logic       active;

  modport master (
    input  data_in,
    output data_000,
    output valid_000,
    output active
  );

  modport slave (
    output data_in,
    input  data_000,
    input  valid_000,
    input  active
  );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-byte deserializer for phy_rx: locks on the 0xBC comma, then emits aligned bytes.
// Optional loss-of-sync watchdog is compiled in when S2P_RESYNC_EN is defined.
module serial_to_parallel_rx #(
  parameter logic [7:0]  BC      = 8'hBC,
  parameter int unsigned BC_LOCK = 4
`ifdef S2P_RESYNC_EN
  ,
  parameter int unsigned WDOG_BYTES = 64
`endif
) (
  input  logic                   clk_16f,
  input  logic                   reset_L,
  serial_to_parallel_rx_if.master rx_if
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_t;

  localparam logic [2:0] BC_LOCK_C = 3'(BC_LOCK);
`ifdef S2P_RESYNC_EN
  localparam logic [5:0] WDOG_LAST = 6'(WDOG_BYTES - 1);
`endif

  state_t     state;
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [2:0] bc_cnt;
  logic [7:0] cand;
  logic       boundary;
`ifdef S2P_RESYNC_EN
  logic [5:0] wdog;
`endif

  always_comb begin
    cand     = {sr, rx_if.data_in};
    boundary = (bit_cnt == 3'd7);
  end

  always_ff @(posedge clk_16f) begin
    if (!reset_L) begin
      state           <= SEARCH;
      sr              <= '0;
      bit_cnt         <= '0;
      bc_cnt          <= '0;
      rx_if.data_000  <= '0;
      rx_if.valid_000 <= 1'b0;
      rx_if.active    <= 1'b0;
`ifdef S2P_RESYNC_EN
      wdog            <= '0;
`endif
    end else begin
      sr      <= cand[6:0];
      bit_cnt <= bit_cnt + 3'd1;

      case (state)
        SEARCH: begin
          // A hit at any offset redefines the byte phase: the next boundary is 8 bits later.
          if (cand == BC) begin
            bit_cnt <= '0;
            bc_cnt  <= 3'd1;
            state   <= ALIGN;
          end
        end

        ALIGN: begin
          if (boundary) begin
            if (cand == BC) begin
              bc_cnt <= bc_cnt + 3'd1;
              if (bc_cnt + 3'd1 == BC_LOCK_C) begin
                state        <= ACTIVE;
                rx_if.active <= 1'b1;
`ifdef S2P_RESYNC_EN
                wdog         <= '0;
`endif
              end
            end else begin
              bc_cnt <= '0;
              state  <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          if (boundary) begin
            rx_if.data_000  <= cand;
            rx_if.valid_000 <= (cand != BC);
`ifdef S2P_RESYNC_EN
            // Trip overrides the byte just captured so the demux sees idle on loss of sync.
            if (cand == BC) begin
              wdog <= '0;
            end else if (wdog == WDOG_LAST) begin
              wdog            <= '0;
              state           <= SEARCH;
              bc_cnt          <= '0;
              rx_if.data_000  <= '0;
              rx_if.valid_000 <= 1'b0;
              rx_if.active    <= 1'b0;
            end else begin
              wdog <= wdog + 6'd1;
            end
`endif
          end
        end

        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: directed scenarios with random payloads,
// compared each cycle against a bit-stream reference model (watchdog checks follow S2P_RESYNC_EN).
module tb_serial_to_parallel_rx;

  localparam logic [7:0] BC = 8'hBC;

  logic clk;
  logic reset_L;

  serial_to_parallel_rx_if bus ();

  serial_to_parallel_rx dut (
    .clk_16f (clk),
    .reset_L (reset_L),
    .rx_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sliding 8-bit window over the line, phase tracked as bits since last lock hit.
  logic [7:0] m_win;
  int         m_since;
  int         m_runs;
  bit         m_align;
  bit         m_act;
  int         m_idle;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_act;

  task automatic model_step(input logic b, input logic rst_n);
    if (!rst_n) begin
      m_win = 8'h00; m_since = 0; m_runs = 0; m_align = 0; m_act = 0; m_idle = 0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_act = 1'b0;
    end else begin
      m_win   = {m_win[6:0], b};
      m_since = m_since + 1;
      if (!m_align && !m_act) begin
        if (m_win == BC) begin
          m_since = 0; m_runs = 1; m_align = 1;
        end
      end else if (m_since % 8 == 0) begin
        if (m_act) begin
          exp_data  = m_win;
          exp_valid = (m_win != BC);
          m_idle    = (m_win == BC) ? 0 : m_idle + 1;
`ifdef S2P_RESYNC_EN
          if (m_idle == 64) begin
            m_act = 0; m_runs = 0; m_idle = 0;
            exp_data = 8'h00; exp_valid = 1'b0; exp_act = 1'b0;
          end
`endif
        end else if (m_win == BC) begin
          m_runs = m_runs + 1;
          if (m_runs == 4) begin
            m_align = 0; m_act = 1; m_idle = 0; exp_act = 1'b1;
          end
        end else begin
          m_align = 0; m_runs = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic b, input logic rst_n);
    bus.data_in = b;
    reset_L     = rst_n;
    @(posedge clk);
    #1;
    model_step(b, rst_n);
    chk("model_data", bus.data_000, exp_data);
    chk("model_valid", {7'd0, bus.valid_000}, {7'd0, exp_valid});
    chk("model_active", {7'd0, bus.active}, {7'd0, exp_act});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) tick(v[i], 1'b1);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, "_data"}, bus.data_000, d);
    chk({tag, "_valid"}, {7'd0, bus.valid_000}, {7'd0, v});
    chk({tag, "_active"}, {7'd0, bus.active}, {7'd0, a});
  endtask

  function automatic logic [7:0] rand_non_bc();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    if (r == BC) r = 8'h3C;
    return r;
  endfunction

  initial begin
    logic [7:0] pay;

    bus.data_in = 1'b0;
    reset_L     = 1'b0;

    // Reset held for 3 cycles with random line activity.
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b0);
      expect_out("reset_hold", 8'h00, 1'b0, 1'b0);
    end
    // First cycle after release doubles as the first of three junk bits.
    tick(1'($urandom_range(0, 1)), 1'b1);
    expect_out("reset_release", 8'h00, 1'b0, 1'b0);
    tick(1'($urandom_range(0, 1)), 1'b1);
    tick(1'($urandom_range(0, 1)), 1'b1);

    // Lock at an odd bit offset.
    for (int k = 1; k <= 3; k++) begin
      send_byte(BC);
      expect_out("lock_pre", 8'h00, 1'b0, 1'b0);
    end
    send_byte(BC);
    expect_out("lock_4th_bc", 8'h00, 1'b0, 1'b1);
    send_byte(8'h12);
    expect_out("lock_first_payload", 8'h12, 1'b1, 1'b1);

    // Idle filtering in ACTIVE.
    send_byte(8'hBC); expect_out("idle_bc0", 8'hBC, 1'b0, 1'b1);
    send_byte(8'h00); expect_out("idle_00", 8'h00, 1'b1, 1'b1);
    send_byte(8'hFF); expect_out("idle_ff", 8'hFF, 1'b1, 1'b1);
    send_byte(8'hBC); expect_out("idle_bc1", 8'hBC, 1'b0, 1'b1);

    // Reset asserted at bit 4 of a payload byte.
    pay = rand_non_bc();
    for (int i = 7; i >= 4; i--) tick(pay[i], 1'b1);
    tick(pay[3], 1'b0);
    expect_out("midbyte_reset", 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      send_byte(BC);
      expect_out("relock_pre", 8'h00, 1'b0, 1'b0);
    end
    send_byte(BC);
    expect_out("relock_4th_bc", 8'h00, 1'b0, 1'b1);
    pay = rand_non_bc();
    send_byte(pay);
    expect_out("relock_payload", pay, 1'b1, 1'b1);

    // Failed lock: a short BC run is abandoned on a non-BC byte.
    tick(1'($urandom_range(0, 1)), 1'b0);
    tick(1'($urandom_range(0, 1)), 1'b0);
    for (int k = 0; k < 3; k++) send_byte(BC);
    send_byte(8'h55);
    expect_out("fail_after_55", 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      send_byte(BC);
      expect_out("fail_rerun_pre", 8'h00, 1'b0, 1'b0);
    end
    send_byte(BC);
    expect_out("fail_rerun_lock", 8'h00, 1'b0, 1'b1);
    send_byte(8'hA7);
    expect_out("fail_a7", 8'hA7, 1'b1, 1'b1);

    // Random traffic with occasional idles.
    for (int k = 0; k < 40; k++) begin
      pay = ($urandom_range(0, 7) == 0) ? BC : 8'($urandom_range(0, 255));
      send_byte(pay);
      expect_out("rand_traffic", pay, (pay != BC), 1'b1);
    end

    // Watchdog: a BC clears the idle run, then 64 non-BC bytes.
    send_byte(BC);
    for (int k = 1; k <= 63; k++) send_byte(rand_non_bc());
    chk("wdog_63_active", {7'd0, bus.active}, 8'd1);
    pay = rand_non_bc();
    send_byte(pay);
`ifdef S2P_RESYNC_EN
    expect_out("wdog_trip", 8'h00, 1'b0, 1'b0);
`else
    expect_out("wdog_absent", pay, 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
